// File: rtl/philv_stage_pipe.sv
// Elastic valid/ready pipeline of DEPTH registered stages with bubble collapsing
// and synchronous flush; replaces the always-enabled EX/MEM/WB stage registers.
module philv_stage_pipe #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_valid;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] up_data [DEPTH];
  logic [OCC_W-1:0] occupancy_q, occupancy_d;

  // A stage can advance unless it and every stage downstream of it are full
  // while the output is blocked; walking from the output end avoids a
  // self-referencing ready chain.
  always_comb begin
    logic tail_full;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    tail_full = 1'b1;
    rdy       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tail_full = tail_full & valid_q[i];
      rdy[i]    = !tail_full || out_ready;
    end
  end

  always_comb begin
    up_valid    = valid_q << 1;
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_data[i] = data_q[i-1];
    end

    valid_d     = valid_q;
    load        = '0;
    occupancy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // Data only moves for valid entries, so bubbles leave registers quiet.
      load[i]    = !flush && rdy[i] && up_valid[i];
      valid_d[i] = flush ? 1'b0 : (rdy[i] ? up_valid[i] : valid_q[i]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      occupancy_d = occupancy_d + OCC_W'(valid_d[i]);
    end
  end

  // NOTE: the data registers are reset so RESET_VALUE is visible on out_data
  // straight after reset; they are flops, not a RAM, so this is cheap to route.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      valid_q     <= '0;
      occupancy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VALUE;
      end
    end else begin
      // NOTE: non-blocking assignments keep every stage sampling pre-edge values.
      valid_q     <= valid_d;
      occupancy_q <= occupancy_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) begin
          data_q[i] <= up_data[i];
        end
      end
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = valid_q[DEPTH-1] && !flush;
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_philv_stage_pipe.sv
// Self-checking bench for philv_stage_pipe: directed scenarios on a DEPTH=4 and a
// DEPTH=1 instance, plus random traffic against an entry-position model.
module tb_philv_stage_pipe;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;

  logic        a_in_valid = 1'b0, a_out_ready = 1'b0, a_flush = 1'b0;
  logic [31:0] a_in_data = '0;
  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [2:0]  a_occ;

  logic        b_in_valid = 1'b0, b_out_ready = 1'b0, b_flush = 1'b0;
  logic [7:0]  b_in_data = '0;
  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_out_data;
  logic [0:0]  b_occ;

  int n_run = 0;
  int n_fail = 0;

  // Model: in-flight entries, oldest first, each with the stage it sits in.
  int          m_pos[$];
  logic [31:0] m_val[$];

  always #5 clk = ~clk;

  philv_stage_pipe #(.WIDTH(32), .DEPTH(D), .RESET_VALUE(32'h0)) u_a (
    .clk(clk), .rstb(rstb),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .flush(a_flush), .occupancy(a_occ)
  );

  philv_stage_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'hA5)) u_b (
    .clk(clk), .rstb(rstb),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .flush(b_flush), .occupancy(b_occ)
  );

  // Moves each entry one stage forward if the stage ahead will be free, the
  // oldest leaving when it is at the output and out_ready is high. Returns
  // whether stage 0 ends up free (the expected in_ready).
  function automatic bit m_eval(input bit ordy, input bit fl, input bit apply,
                                input bit iv, input logic [31:0] id);
    int blocked;
    int np[$];
    bit leaves;
    if (fl) begin
      if (apply) begin
        m_pos.delete();
        m_val.delete();
      end
      return 1'b0;
    end
    blocked = D;
    leaves  = 1'b0;
    for (int k = 0; k < m_pos.size(); k++) begin
      int p;
      p = m_pos[k];
      if (k == 0 && p == D - 1 && ordy) begin
        leaves = 1'b1;
        np.push_back(D);
      end else begin
        if (p + 1 < blocked) p = p + 1;
        np.push_back(p);
        blocked = p;
      end
    end
    if (apply) begin
      for (int k = 0; k < m_pos.size(); k++) m_pos[k] = np[k];
      if (leaves) begin
        void'(m_pos.pop_front());
        void'(m_val.pop_front());
      end
      if (blocked > 0 && iv) begin
        m_pos.push_back(0);
        m_val.push_back(id);
      end
    end
    return blocked > 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_in_valid = 0; a_out_ready = 0; a_flush = 0;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    @(negedge clk);
    n_run++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_init_out_valid: got %b expected 0", a_out_valid); end
    n_run++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL rst_init_occ: got %0d expected 0", a_occ); end
    n_run++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_init_in_ready: got %b expected 1", a_in_ready); end
    tick();
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1; a_in_data = 32'h111 * (k + 1);
      tick();
    end
    a_in_valid = 0;
    @(negedge clk);
    n_run++; if (a_occ !== 3'd3) begin n_fail++; $display("FAIL rst_inflight_occ: got %0d expected 3", a_occ); end
    #2 rstb = 1'b0;
    #1;
    n_run++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_out_valid: got %b expected 0", a_out_valid); end
    n_run++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL rst_async_occ: got %0d expected 0", a_occ); end
    n_run++; if (a_out_data !== 32'h0) begin n_fail++; $display("FAIL rst_async_out_data: got %h expected 0", a_out_data); end
    n_run++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_in_ready: got %b expected 1", a_in_ready); end
    tick();
    rstb = 1'b1;
    @(negedge clk);
    n_run++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL rst_after_occ: got %0d expected 0", a_occ); end
    tick();
  endtask

  task automatic test_streaming();
    int  peak;
    bit  exp_v;
    peak = 0;
    for (int c = 0; c < 14; c++) begin
      a_in_valid = (c < 8); a_in_data = c + 1; a_out_ready = 1;
      @(negedge clk);
      exp_v = (c >= 4 && c < 12);
      n_run++; if (a_out_valid !== exp_v) begin n_fail++; $display("FAIL stream_out_valid c=%0d: got %b expected %b", c, a_out_valid, exp_v); end
      if (exp_v) begin
        n_run++; if (a_out_data !== 32'(c - 3)) begin n_fail++; $display("FAIL stream_out_data c=%0d: got %0d expected %0d", c, a_out_data, c - 3); end
      end
      if (c < 8) begin
        n_run++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c=%0d: got %b expected 1", c, a_in_ready); end
      end
      if (int'(a_occ) > peak) peak = int'(a_occ);
      tick();
    end
    a_in_valid = 0;
    n_run++; if (peak !== 4) begin n_fail++; $display("FAIL stream_peak_occ: got %0d expected 4", peak); end
  endtask

  task automatic test_back_pressure();
    int acc, got;
    bit exp_r;
    acc = 0; got = 0;
    a_out_ready = 0;
    for (int c = 0; c < 7; c++) begin
      a_in_valid = 1; a_in_data = 10 + acc;
      @(negedge clk);
      exp_r = (c < 4);
      n_run++; if (a_in_ready !== exp_r) begin n_fail++; $display("FAIL bp_in_ready c=%0d: got %b expected %b", c, a_in_ready, exp_r); end
      if (a_in_valid && a_in_ready) acc++;
      tick();
    end
    @(negedge clk);
    n_run++; if (a_occ !== 3'd4) begin n_fail++; $display("FAIL bp_full_occ: got %0d expected 4", a_occ); end
    n_run++; if (a_out_data !== 32'd10 || a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full_head: got %0d/%b expected 10/1", a_out_data, a_out_valid); end
    tick();
    a_out_ready = 1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      a_in_valid = (acc < 5); a_in_data = 10 + acc;
      @(negedge clk);
      if (c == 0) begin
        n_run++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_full_pass_in_ready: got %b expected 1", a_in_ready); end
      end
      if (c == 1) begin
        n_run++; if (a_occ !== 3'd4) begin n_fail++; $display("FAIL bp_full_pass_occ: got %0d expected 4", a_occ); end
      end
      if (a_out_valid) begin
        n_run++; if (a_out_data !== 32'(10 + got)) begin n_fail++; $display("FAIL bp_drain_data: got %0d expected %0d", a_out_data, 10 + got); end
        got++;
      end
      if (a_in_valid && a_in_ready) acc++;
      tick();
    end
    a_in_valid = 0;
    n_run++; if (got !== 5) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected 5", got); end
  endtask

  task automatic test_bubble();
    a_out_ready = 0;
    for (int c = 0; c < 8; c++) begin
      a_in_valid = (c == 0 || c == 3);
      a_in_data  = (c == 0) ? 32'd5 : 32'd6;
      @(negedge clk);
      n_run++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bub_in_ready c=%0d: got %b expected 1", c, a_in_ready); end
      if (c == 7) begin
        n_run++; if (a_occ !== 3'd2) begin n_fail++; $display("FAIL bub_occ: got %0d expected 2", a_occ); end
        n_run++; if (a_out_valid !== 1'b1 || a_out_data !== 32'd5) begin n_fail++; $display("FAIL bub_head: got %0d/%b expected 5/1", a_out_data, a_out_valid); end
      end
      tick();
    end
    a_in_valid = 0; a_out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_run++; if (a_out_valid !== (c < 2)) begin n_fail++; $display("FAIL bub_drain_valid c=%0d: got %b expected %b", c, a_out_valid, c < 2); end
      if (c < 2) begin
        n_run++; if (a_out_data !== 32'(5 + c)) begin n_fail++; $display("FAIL bub_drain_data c=%0d: got %0d expected %0d", c, a_out_data, 5 + c); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    a_out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      a_in_valid = 1; a_in_data = 20 + c;
      tick();
    end
    @(negedge clk);
    n_run++; if (a_occ !== 3'd4) begin n_fail++; $display("FAIL fl_full_occ: got %0d expected 4", a_occ); end
    tick();
    a_flush = 1; a_in_valid = 1; a_in_data = 99; a_out_ready = 1;
    @(negedge clk);
    n_run++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_in_ready: got %b expected 0", a_in_ready); end
    n_run++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_out_valid: got %b expected 0", a_out_valid); end
    tick();
    a_flush = 0; a_in_valid = 0;
    @(negedge clk);
    n_run++; if (a_occ !== 3'd0) begin n_fail++; $display("FAIL fl_after_occ: got %0d expected 0", a_occ); end
    n_run++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_after_in_ready: got %b expected 1", a_in_ready); end
    for (int c = 0; c < 5; c++) begin
      n_run++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_after_out_valid c=%0d: got %b expected 0", c, a_out_valid); end
      tick();
      @(negedge clk);
    end
    tick();
  endtask

  task automatic test_random();
    bit          iv, ordy, fl, pending, exp_r, exp_v;
    logic [31:0] id;
    a_in_valid = 0; a_flush = 0;
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    m_pos.delete(); m_val.delete();
    pending = 0; iv = 0; id = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pending) begin
        iv = ($urandom_range(0, 3) != 0);
        id = $urandom;
      end
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      a_in_valid = iv; a_in_data = id; a_out_ready = ordy; a_flush = fl;
      @(negedge clk);
      exp_r = m_eval(ordy, fl, 1'b0, iv, id);
      exp_v = !fl && m_pos.size() > 0 && m_pos[0] == D - 1;
      n_run++; if (a_in_ready !== exp_r) begin n_fail++; $display("FAIL rand_in_ready c=%0d: got %b expected %b", c, a_in_ready, exp_r); end
      n_run++; if (a_out_valid !== exp_v) begin n_fail++; $display("FAIL rand_out_valid c=%0d: got %b expected %b", c, a_out_valid, exp_v); end
      if (exp_v) begin
        n_run++; if (a_out_data !== m_val[0]) begin n_fail++; $display("FAIL rand_out_data c=%0d: got %h expected %h", c, a_out_data, m_val[0]); end
      end
      n_run++; if (int'(a_occ) !== m_pos.size()) begin n_fail++; $display("FAIL rand_occ c=%0d: got %0d expected %0d", c, a_occ, m_pos.size()); end
      @(posedge clk);
      void'(m_eval(ordy, fl, 1'b1, iv, id));
      pending = iv && !exp_r && !fl;
      #1;
    end
    a_in_valid = 0; a_flush = 0;
  endtask

  task automatic test_depth1();
    b_in_valid = 0; b_out_ready = 0; b_flush = 0;
    @(negedge clk);
    n_run++; if (b_out_data !== 8'hA5) begin n_fail++; $display("FAIL d1_reset_data: got %h expected a5", b_out_data); end
    n_run++; if (b_out_valid !== 1'b0 || b_occ !== 1'b0) begin n_fail++; $display("FAIL d1_reset_empty: got %b/%0d expected 0/0", b_out_valid, b_occ); end
    tick();
    b_in_valid = 1; b_in_data = 8'h3C;
    @(negedge clk);
    n_run++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL d1_empty_in_ready: got %b expected 1", b_in_ready); end
    tick();
    b_in_data = 8'h7E;
    @(negedge clk);
    n_run++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL d1_full_in_ready: got %b expected 0", b_in_ready); end
    n_run++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h3C) begin n_fail++; $display("FAIL d1_full_head: got %h/%b expected 3c/1", b_out_data, b_out_valid); end
    tick();
    b_out_ready = 1;
    @(negedge clk);
    n_run++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL d1_pass_in_ready: got %b expected 1", b_in_ready); end
    n_run++; if (b_out_data !== 8'h3C) begin n_fail++; $display("FAIL d1_pass_head: got %h expected 3c", b_out_data); end
    tick();
    b_in_valid = 0;
    @(negedge clk);
    n_run++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h7E || b_occ !== 1'b1) begin n_fail++; $display("FAIL d1_second: got %h/%b/%0d expected 7e/1/1", b_out_data, b_out_valid, b_occ); end
    tick();
    @(negedge clk);
    n_run++; if (b_out_valid !== 1'b0 || b_occ !== 1'b0) begin n_fail++; $display("FAIL d1_drained: got %b/%0d expected 0/0", b_out_valid, b_occ); end
    tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_bubble();
    test_flush();
    test_depth1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
